// File: rtl/id_ex_ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_pipe_pkg
// Shared definitions for the 16-bit, 8-register 5-stage core control path:
// opcode constants, the NOP encoding, the ID/EX control FSM state type, and
// the operand-usage helpers. The decoder and the forwarding detector also use
// these helpers.
// ---------------------------------------------------------------------------
package id_ex_ctrl_pipe_pkg;

  localparam int PIPE_IW = 16;  // instruction width
  localparam int PIPE_RW = 3;   // register-index width (8 GPRs)

  // Canonical no-op. Bubbles and reset fill the ID/EX instruction copy with it.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Opcodes (instr[15:11]) that matter for operand-usage decisions
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_SIIC = 5'b00010;
  localparam logic [4:0] OP_RTI  = 5'b00011;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_BTR  = 5'b11001;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  // Instruction reads its Rs field (instr[10:8]).
  function automatic logic rs_used(input logic [4:0] op);
    case (op)
      OP_HALT, OP_NOP, OP_SIIC, OP_RTI, OP_J, OP_JAL, OP_LBI: rs_used = 1'b0;
      default:                                               rs_used = 1'b1;
    endcase
  endfunction

  // Instruction reads its Rt field (instr[7:5]): R-format ALU ops plus stores.
  function automatic logic rt_used(input logic [4:0] op);
    rt_used = ((op[4:3] == 2'b11) && (op != OP_LBI) && (op != OP_BTR)) ||
              (op == OP_ST) || (op == OP_STU);
  endfunction

endpackage

// File: rtl/id_ex_ctrl_pipe_pipe_ctrl_reg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_reg
// Generic pipeline control register with enable and synchronous bubble-clear.
//  clk  in  1   clock
//  rst  in  1   asynchronous, active-low reset (loads RST_VAL)
//  en   in  1   register updates only when set (pipeline freeze when clear)
//  clr  in  1   with en, load CLR_VAL instead of d (inject a bubble)
//  d    in  W   next-stage value
//  q    out W   registered value
// ---------------------------------------------------------------------------
module pipe_ctrl_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= clr ? CLR_VAL : d;
    end
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_pipe
// Control-side ID/EX and EX/MEM pipeline registers with load-use hazard
// detection, branch squash and HALT freeze.
//  clk            in   1   core clock
//  rst            in   1   asynchronous, active-low reset
//  instr_id       in   IW  instruction in ID
//  valid_id       in   1   instr_id is real (0 = bubble)
//  reg_wrt_dec    in   1   ID instruction writes a register
//  mem_read_dec   in   1   ID instruction is a load
//  mem_wrt_dec    in   1   ID instruction is a store
//  target_dec     in   RW  ID destination register
//  halt_dec       in   1   ID instruction is HALT
//  flush          in   1   taken branch in EX; squash the ID instruction
//  Reg_wrt_reg_ID out  1   EX-stage writes a register
//  target_reg_ID  out  RW  EX-stage destination
//  Mem_read_ID    out  1   EX-stage is a load
//  Mem_wrt_reg_ID out  1   EX-stage is a store
//  instr_ex       out  IW  EX-stage instruction copy
//  Reg_wrt_reg_EX out  1   MEM-stage writes a register
//  target_reg_EX  out  RW  MEM-stage destination
//  Mem_read_EX    out  1   MEM-stage is a load
//  stall          out  1   hold PC and IF/ID this cycle
//  halted         out  1   HALT reached MEM; pipeline frozen
// ---------------------------------------------------------------------------
module id_ex_ctrl_pipe
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int IW = PIPE_IW,
  parameter int RW = PIPE_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_id,
  input  logic          valid_id,
  input  logic          reg_wrt_dec,
  input  logic          mem_read_dec,
  input  logic          mem_wrt_dec,
  input  logic [RW-1:0] target_dec,
  input  logic          halt_dec,
  input  logic          flush,
  output logic          Reg_wrt_reg_ID,
  output logic [RW-1:0] target_reg_ID,
  output logic          Mem_read_ID,
  output logic          Mem_wrt_reg_ID,
  output logic [IW-1:0] instr_ex,
  output logic          Reg_wrt_reg_EX,
  output logic [RW-1:0] target_reg_EX,
  output logic          Mem_read_EX,
  output logic          stall,
  output logic          halted
);

  // ID/EX entry: {halt, reg_wrt, mem_read, mem_wrt, target, instr}
  localparam int IDEX_W  = 4 + RW + IW;
  // EX/MEM entry: {reg_wrt, mem_read, target}
  localparam int EXMEM_W = 2 + RW;

  localparam logic [IDEX_W-1:0]  IDEX_EMPTY  = {4'b0000, {RW{1'b0}}, IW'(NOP_INSTR)};
  localparam logic [EXMEM_W-1:0] EXMEM_EMPTY = '0;

  pipe_state_t state, state_next;

  logic [4:0]         op;
  logic               rs_hit;
  logic               rt_hit;
  logic               load_use;
  logic               load_stall;
  logic               advance;
  logic               idex_clr;
  logic               idex_halt;
  logic [IDEX_W-1:0]  idex_d;
  logic [IDEX_W-1:0]  idex_q;
  logic [EXMEM_W-1:0] exmem_d;
  logic [EXMEM_W-1:0] exmem_q;

  // ---------------------------------------------------------------------
  // Load-use detection against the load currently sitting in EX
  // ---------------------------------------------------------------------
  assign op     = instr_id[IW-1 -: 5];
  assign rs_hit = rs_used(op) && (instr_id[10:8] == target_reg_ID);
  assign rt_hit = rt_used(op) && (instr_id[7:5]  == target_reg_ID);

  assign load_use = valid_id && Mem_read_ID && Reg_wrt_reg_ID && (rs_hit || rt_hit);

  // A taken branch kills the dependent instruction anyway, so flush cancels the
  // stall. In BUBBLE the load has already moved to MEM where forwarding covers it.
  assign load_stall = load_use && !flush && (state == RUN);

  assign advance  = (state != HALTED);
  assign idex_clr = flush || load_stall || !valid_id;

  assign stall  = load_stall || (state == HALTED);
  assign halted = (state == HALTED);

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  assign idex_d = {halt_dec, reg_wrt_dec, mem_read_dec, mem_wrt_dec, target_dec, instr_id};

  pipe_ctrl_reg #(
    .W       (IDEX_W),
    .RST_VAL (IDEX_EMPTY),
    .CLR_VAL (IDEX_EMPTY)
  ) u_id_ex (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .clr (idex_clr),
    .d   (idex_d),
    .q   (idex_q)
  );

  assign {idex_halt, Reg_wrt_reg_ID, Mem_read_ID, Mem_wrt_reg_ID, target_reg_ID, instr_ex} = idex_q;

  // EX/MEM keeps moving during a load-use stall so the load drains into MEM
  // while the bubble occupies EX.
  assign exmem_d = {Reg_wrt_reg_ID, Mem_read_ID, target_reg_ID};

  pipe_ctrl_reg #(
    .W       (EXMEM_W),
    .RST_VAL (EXMEM_EMPTY),
    .CLR_VAL (EXMEM_EMPTY)
  ) u_ex_mem (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .clr (1'b0),
    .d   (exmem_d),
    .q   (exmem_q)
  );

  assign {Reg_wrt_reg_EX, Mem_read_EX, target_reg_EX} = exmem_q;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A HALT in ID/EX moves into EX/MEM on this edge; freeze from then on.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (idex_halt) begin
          state_next = HALTED;
        end else if (load_stall) begin
          state_next = BUBBLE;
        end
      end
      BUBBLE: begin
        if (idex_halt) begin
          state_next = HALTED;
        end else begin
          state_next = RUN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
`timescale 1ns/1ps
module tb_id_ex_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_id;
  logic        valid_id, reg_wrt_dec, mem_read_dec, mem_wrt_dec;
  logic [2:0]  target_dec;
  logic        halt_dec, flush;
  logic        Reg_wrt_reg_ID, Mem_read_ID, Mem_wrt_reg_ID;
  logic [2:0]  target_reg_ID, target_reg_EX;
  logic [15:0] instr_ex;
  logic        Reg_wrt_reg_EX, Mem_read_EX, stall, halted;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // Hand-encoded instructions: op[15:11] rs[10:8] rt/rd[7:5] ...
  localparam logic [15:0] NOP          = 16'h0800;
  localparam logic [15:0] HALT_I       = 16'h0000;
  localparam logic [15:0] LD_R3        = 16'h8860; // LD  r3,[r0]
  localparam logic [15:0] LD_R2        = 16'h8840; // LD  r2,[r0]
  localparam logic [15:0] LD_R1        = 16'h8820; // LD  r1,[r0]
  localparam logic [15:0] LD_R2_R1     = 16'h8940; // LD  r2,[r1]
  localparam logic [15:0] ADD_R1_R3_R2 = 16'hDB44; // ADD r1,r3,r2
  localparam logic [15:0] ADD_R1_R2_R4 = 16'hDA84; // ADD r1,r2,r4
  localparam logic [15:0] ADD_R4_R2_R2 = 16'hDA50; // ADD r4,r2,r2
  localparam logic [15:0] ADD_R3_R2_R2 = 16'hDA4C; // ADD r3,r2,r2
  localparam logic [15:0] LBI_R3_5     = 16'hC305; // LBI r3,#5

  id_ex_ctrl_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .instr_id       (instr_id),
    .valid_id       (valid_id),
    .reg_wrt_dec    (reg_wrt_dec),
    .mem_read_dec   (mem_read_dec),
    .mem_wrt_dec    (mem_wrt_dec),
    .target_dec     (target_dec),
    .halt_dec       (halt_dec),
    .flush          (flush),
    .Reg_wrt_reg_ID (Reg_wrt_reg_ID),
    .target_reg_ID  (target_reg_ID),
    .Mem_read_ID    (Mem_read_ID),
    .Mem_wrt_reg_ID (Mem_wrt_reg_ID),
    .instr_ex       (instr_ex),
    .Reg_wrt_reg_EX (Reg_wrt_reg_EX),
    .target_reg_EX  (target_reg_EX),
    .Mem_read_EX    (Mem_read_EX),
    .stall          (stall),
    .halted         (halted)
  );

  task automatic drive(input logic [15:0] ins, input logic v, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] t, input logic h, input logic f);
    instr_id = ins; valid_id = v; reg_wrt_dec = rw; mem_read_dec = mr;
    mem_wrt_dec = mw; target_dec = t; halt_dec = h; flush = f;
  endtask

  task automatic drive_idle();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic drive_ld(input logic [15:0] ins, input logic [2:0] t);
    drive(ins, 1'b1, 1'b1, 1'b1, 1'b0, t, 1'b0, 1'b0);
  endtask

  task automatic drive_alu(input logic [15:0] ins, input logic [2:0] t, input logic f);
    drive(ins, 1'b1, 1'b1, 1'b0, 1'b0, t, 1'b0, f);
  endtask

  // Outputs are sampled 1 ns after the active edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive_idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) tick();
    vec_cnt++; if (instr_ex !== NOP) begin err_cnt++; $display("FAIL rst_instr_ex: got %h expected %h", instr_ex, NOP); end
    vec_cnt++; if ({Reg_wrt_reg_ID, Mem_read_ID, Mem_wrt_reg_ID, target_reg_ID} !== 6'b0) begin err_cnt++; $display("FAIL rst_idex_ctrl: got %b expected 0", {Reg_wrt_reg_ID, Mem_read_ID, Mem_wrt_reg_ID, target_reg_ID}); end
    vec_cnt++; if ({Reg_wrt_reg_EX, Mem_read_EX, target_reg_EX} !== 5'b0) begin err_cnt++; $display("FAIL rst_exmem_ctrl: got %b expected 0", {Reg_wrt_reg_EX, Mem_read_EX, target_reg_EX}); end
    vec_cnt++; if ({stall, halted} !== 2'b00) begin err_cnt++; $display("FAIL rst_stall_halted: got %b expected 00", {stall, halted}); end
    rst = 1'b1;
    $display("reset: power-up state checked");
  endtask

  task automatic test_load_use();
    drive_ld(LD_R3, 3'd3);
    #2;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL lu_ld_nostall: got %b expected 0", stall); end
    tick();
    vec_cnt++; if ({Reg_wrt_reg_ID, Mem_read_ID, target_reg_ID, instr_ex} !== {1'b1, 1'b1, 3'd3, LD_R3}) begin err_cnt++; $display("FAIL lu_ld_in_ex: got %b %b %0d %h expected 1 1 3 %h", Reg_wrt_reg_ID, Mem_read_ID, target_reg_ID, instr_ex, LD_R3); end
    drive_alu(ADD_R1_R3_R2, 3'd1, 1'b0);
    #2;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL lu_stall: got %b expected 1", stall); end
    tick();
    vec_cnt++; if ({Reg_wrt_reg_ID, Mem_read_ID, instr_ex} !== {1'b0, 1'b0, NOP}) begin err_cnt++; $display("FAIL lu_bubble: got %b %b %h expected 0 0 %h", Reg_wrt_reg_ID, Mem_read_ID, instr_ex, NOP); end
    vec_cnt++; if ({Reg_wrt_reg_EX, target_reg_EX, Mem_read_EX} !== {1'b1, 3'd3, 1'b1}) begin err_cnt++; $display("FAIL lu_ld_in_mem: got %b %0d %b expected 1 3 1", Reg_wrt_reg_EX, target_reg_EX, Mem_read_EX); end
    #2;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL lu_single_stall: got %b expected 0", stall); end
    tick();
    vec_cnt++; if ({instr_ex, target_reg_ID, Reg_wrt_reg_ID} !== {ADD_R1_R3_R2, 3'd1, 1'b1}) begin err_cnt++; $display("FAIL lu_add_in_ex: got %h %0d %b expected %h 1 1", instr_ex, target_reg_ID, Reg_wrt_reg_ID, ADD_R1_R3_R2); end
    drive_idle();
    tick();
    vec_cnt++; if ({Reg_wrt_reg_EX, target_reg_EX, Mem_read_EX} !== {1'b1, 3'd1, 1'b0}) begin err_cnt++; $display("FAIL lu_add_in_mem: got %b %0d %b expected 1 1 0", Reg_wrt_reg_EX, target_reg_EX, Mem_read_EX); end
    $display("load_use: LD r3 -> ADD r1,r3,r2 checked");
    drain();
  endtask

  task automatic test_no_false_stall();
    drive_ld(LD_R3, 3'd3);
    tick();
    drive_alu(LBI_R3_5, 3'd3, 1'b0);
    #2;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL nfs_lbi: got stall %b expected 0", stall); end
    tick();
    vec_cnt++; if (instr_ex !== LBI_R3_5) begin err_cnt++; $display("FAIL nfs_lbi_ex: got %h expected %h", instr_ex, LBI_R3_5); end
    drain();
    drive_ld(LD_R3, 3'd3);
    tick();
    drive_alu(ADD_R1_R2_R4, 3'd1, 1'b0);
    #2;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL nfs_add: got stall %b expected 0", stall); end
    tick();
    vec_cnt++; if (instr_ex !== ADD_R1_R2_R4) begin err_cnt++; $display("FAIL nfs_add_ex: got %h expected %h", instr_ex, ADD_R1_R2_R4); end
    $display("no_false_stall: LBI and independent ADD checked");
    drain();
  endtask

  task automatic test_flush_stall();
    drive_ld(LD_R2, 3'd2);
    tick();
    drive_alu(ADD_R4_R2_R2, 3'd4, 1'b1);
    #2;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL fl_stall: got %b expected 0", stall); end
    tick();
    vec_cnt++; if ({Reg_wrt_reg_ID, target_reg_ID, instr_ex} !== {1'b0, 3'd0, NOP}) begin err_cnt++; $display("FAIL fl_bubble: got %b %0d %h expected 0 0 %h", Reg_wrt_reg_ID, target_reg_ID, instr_ex, NOP); end
    vec_cnt++; if ({Reg_wrt_reg_EX, target_reg_EX, Mem_read_EX} !== {1'b1, 3'd2, 1'b1}) begin err_cnt++; $display("FAIL fl_ld_mem: got %b %0d %b expected 1 2 1", Reg_wrt_reg_EX, target_reg_EX, Mem_read_EX); end
    // FSM must still be in RUN: the next load-use stalls at once.
    drive_ld(LD_R3, 3'd3);
    tick();
    drive_alu(ADD_R1_R3_R2, 3'd1, 1'b0);
    #2;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL fl_run_after: got stall %b expected 1", stall); end
    tick();
    $display("flush_stall: flush overrides load-use checked");
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    logic        prog_mr [3];
    logic [2:0]  prog_t [3];
    logic        exp_stall [7];
    logic [15:0] exp_ex [7];
    logic        seen_stall;
    int          pc;
    int          stalls;
    prog = '{LD_R1, LD_R2_R1, ADD_R3_R2_R2};
    prog_mr = '{1'b1, 1'b1, 1'b0};
    prog_t = '{3'd1, 3'd2, 3'd3};
    exp_stall = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_ex = '{LD_R1, NOP, LD_R2_R1, NOP, ADD_R3_R2_R2, NOP, NOP};
    pc = 0;
    stalls = 0;
    for (int c = 0; c < 7; c++) begin
      if (pc < 3) drive(prog[pc], 1'b1, 1'b1, prog_mr[pc], 1'b0, prog_t[pc], 1'b0, 1'b0);
      else drive_idle();
      #2;
      seen_stall = stall;
      if (seen_stall === 1'b1) stalls++;
      vec_cnt++; if (seen_stall !== exp_stall[c]) begin err_cnt++; $display("FAIL b2b_stall[%0d]: got %b expected %b", c, seen_stall, exp_stall[c]); end
      tick();
      vec_cnt++; if (instr_ex !== exp_ex[c]) begin err_cnt++; $display("FAIL b2b_ex[%0d]: got %h expected %h", c, instr_ex, exp_ex[c]); end
      if (seen_stall !== 1'b1 && pc < 3) pc++;
    end
    vec_cnt++; if (stalls != 2) begin err_cnt++; $display("FAIL b2b_count: got %0d stalls expected 2", stalls); end
    $display("back_to_back: LD r1; LD r2,[r1]; ADD r3,r2,r2 -> %0d stalls", stalls);
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive_ld(LD_R3, 3'd3);
    tick();
    drive_alu(ADD_R1_R3_R2, 3'd1, 1'b0);
    #2;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL rms_pre_stall: got %b expected 1", stall); end
    rst = 1'b0;
    #1;
    vec_cnt++; if ({instr_ex, Mem_read_ID, Reg_wrt_reg_ID, stall, halted} !== {NOP, 4'b0000}) begin err_cnt++; $display("FAIL rms_async: got %h %b%b%b%b expected %h 0000", instr_ex, Mem_read_ID, Reg_wrt_reg_ID, stall, halted, NOP); end
    tick();
    rst = 1'b1;
    #2;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL rms_no_owed_stall: got %b expected 0", stall); end
    tick();
    vec_cnt++; if (instr_ex !== ADD_R1_R3_R2) begin err_cnt++; $display("FAIL rms_add_ex: got %h expected %h", instr_ex, ADD_R1_R3_R2); end
    $display("reset_mid_stall: async clear and clean restart checked");
    drain();
  endtask

  task automatic test_halt();
    drive(HALT_I, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    vec_cnt++; if ({instr_ex, halted} !== {HALT_I, 1'b0}) begin err_cnt++; $display("FAIL halt_in_ex: got %h %b expected %h 0", instr_ex, halted, HALT_I); end
    drive_alu(ADD_R1_R2_R4, 3'd1, 1'b0);
    #2;
    vec_cnt++; if ({stall, halted} !== 2'b00) begin err_cnt++; $display("FAIL halt_not_yet: got %b expected 00", {stall, halted}); end
    tick();
    vec_cnt++; if ({stall, halted} !== 2'b11) begin err_cnt++; $display("FAIL halt_set: got %b expected 11", {stall, halted}); end
    vec_cnt++; if ({instr_ex, target_reg_ID, Reg_wrt_reg_EX} !== {ADD_R1_R2_R4, 3'd1, 1'b0}) begin err_cnt++; $display("FAIL halt_regs: got %h %0d %b expected %h 1 0", instr_ex, target_reg_ID, Reg_wrt_reg_EX, ADD_R1_R2_R4); end
    drive_ld(LD_R3, 3'd3);
    repeat (2) tick();
    vec_cnt++; if ({instr_ex, target_reg_ID, Reg_wrt_reg_ID, Mem_read_ID, Reg_wrt_reg_EX} !== {ADD_R1_R2_R4, 3'd1, 1'b1, 1'b0, 1'b0}) begin err_cnt++; $display("FAIL halt_frozen: got %h %0d %b %b %b expected %h 1 1 0 0", instr_ex, target_reg_ID, Reg_wrt_reg_ID, Mem_read_ID, Reg_wrt_reg_EX, ADD_R1_R2_R4); end
    vec_cnt++; if ({stall, halted} !== 2'b11) begin err_cnt++; $display("FAIL halt_hold: got %b expected 11", {stall, halted}); end
    rst = 1'b0;
    #1;
    vec_cnt++; if ({stall, halted, instr_ex} !== {2'b00, NOP}) begin err_cnt++; $display("FAIL halt_reset_exit: got %b %h expected 00 %h", {stall, halted}, instr_ex, NOP); end
    tick();
    rst = 1'b1;
    drive_idle();
    tick();
    $display("halt: freeze and reset exit checked");
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    test_reset();
    tick();
    test_load_use();
    test_no_false_stall();
    test_flush_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
